// File: rtl/systolic_pkg.sv
// Shared types, defaults and packing helper for the systolic matrix multiplier.
package systolic_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ACC_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Bit offset of element [row][col] in a row-major packed N x N block.
    function automatic int unsigned blk_off(input int unsigned row, input int unsigned col,
                                            input int unsigned n, input int unsigned w);
        return (row * n + col) * w;
    endfunction

endpackage

// File: rtl/systolic_array_if.sv
// Block hand-off between the loader/splitter (master) and the multiplier (slave).
interface systolic_array_if #(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32
);
    logic                    start;
    logic [N*N*DATA_W-1:0]   a_blk;
    logic [N*N*DATA_W-1:0]   b_blk;
    logic                    ready;
    logic                    done;
    logic [N*N*ACC_W-1:0]    c_blk;

    modport master (output start, a_blk, b_blk, input ready, done, c_blk);
    modport slave  (input start, a_blk, b_blk, output ready, done, c_blk);
endinterface

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the output-stationary array.
module systolic_pe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic signed [DATA_W-1:0] b_out,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod_c;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    // Full-width signed product, sign-extended and added with modulo wrap.
    assign prod_c = a_in * b_in;
    assign acc_d  = acc_q + ACC_W'(prod_c);

    // acc includes this cycle's product so the final sum can be captured on the last MAC edge.
    assign acc = acc_d;

    // Accumulator and operand forwarding registers; clr starts a fresh block.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
            a_out <= '0;
            b_out <= '0;
        end else begin
            acc_q <= acc_d;
            a_out <= a_in;
            b_out <= b_in;
        end
    end

endmodule

// File: rtl/systolic_array.sv
// Output-stationary N x N systolic multiplier: one C = A*B block product per start.
module systolic_array
    import systolic_pkg::*;
#(
    parameter int unsigned N      = 2,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic            clk,
    input  logic            rst,
    systolic_array_if.slave bus
);

    localparam int unsigned T_LAST = 3 * N - 3;
    localparam int unsigned T_W    = $clog2(3 * N - 2);

    state_e                   state_q;
    logic [T_W-1:0]           t_q;
    logic                     done_q;
    logic [N*N*ACC_W-1:0]     c_blk_q;
    logic [N*N*ACC_W-1:0]     c_cap;
    logic                     accept_c;

    logic signed [DATA_W-1:0] a_q    [N][N];
    logic signed [DATA_W-1:0] b_q    [N][N];
    logic signed [DATA_W-1:0] left_c [N];
    logic signed [DATA_W-1:0] top_c  [N];
    logic signed [DATA_W-1:0] a_h    [N][N];
    logic signed [DATA_W-1:0] b_v    [N][N];
    logic signed [ACC_W-1:0]  acc_w  [N][N];

    assign accept_c  = (state_q == ST_IDLE) && bus.start;
    assign bus.ready = (state_q == ST_IDLE);
    assign bus.done  = done_q;
    assign bus.c_blk = c_blk_q;

    // Control FSM with step counter, done pulse and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            done_q  <= 1'b0;
            c_blk_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_COMPUTE;
                        t_q     <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (t_q == T_W'(T_LAST)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        c_blk_q <= c_cap;
                        t_q     <= '0;
                    end else begin
                        t_q <= t_q + T_W'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Operand latches, loaded only on the accepting edge.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    a_q[i][k] <= bus.a_blk[blk_off(i, k, N, DATA_W) +: DATA_W];
                    b_q[i][k] <= bus.b_blk[blk_off(i, k, N, DATA_W) +: DATA_W];
                end
            end
        end
    end

    // Skewed edge feed: row i sees A[i][t-i], column j sees B[t-j][j], zero elsewhere.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            left_c[i] = '0;
            top_c[i]  = '0;
            for (int k = 0; k < N; k++) begin
                if ((state_q == ST_COMPUTE) && (int'(t_q) == i + k)) begin
                    left_c[i] = a_q[i][k];
                    top_c[i]  = b_q[k][i];
                end
            end
        end
    end

    // PE grid: A flows right, B flows down, sums stay in place.
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DATA_W-1:0] a_in_w;
            logic signed [DATA_W-1:0] b_in_w;

            if (j == 0) begin : g_a_edge
                assign a_in_w = left_c[i];
            end else begin : g_a_int
                assign a_in_w = a_h[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in_w = top_c[j];
            end else begin : g_b_int
                assign b_in_w = b_v[i-1][j];
            end

            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (accept_c),
                .a_in  (a_in_w),
                .b_in  (b_in_w),
                .a_out (a_h[i][j]),
                .b_out (b_v[i][j]),
                .acc   (acc_w[i][j])
            );

            assign c_cap[blk_off(i, j, N, ACC_W) +: ACC_W] = acc_w[i][j];
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array (N=2, 16-bit operands, 32-bit results).
module tb_systolic_array;

    localparam int unsigned N    = 2;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 32;
    localparam int unsigned AB_W = N * N * DW;
    localparam int unsigned C_W  = N * N * AW;
    localparam int          LAT  = 3 * N - 1;

    typedef struct {
        string                 name;
        logic signed [DW-1:0]  a [4];
        logic signed [DW-1:0]  b [4];
        logic signed [AW-1:0]  c [4];
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    systolic_array_if #(.N(N), .DATA_W(DW), .ACC_W(AW)) bus ();

    systolic_array #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [C_W-1:0] got, input logic [C_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [AB_W-1:0] pk_ab(input logic signed [DW-1:0] e [4]);
        logic [AB_W-1:0] r;
        r = '0;
        for (int x = 0; x < 4; x++) r[x*DW +: DW] = e[x];
        return r;
    endfunction

    function automatic logic [C_W-1:0] pk_c(input logic signed [AW-1:0] e [4]);
        logic [C_W-1:0] r;
        r = '0;
        for (int x = 0; x < 4; x++) r[x*AW +: AW] = e[x];
        return r;
    endfunction

    // Reference: plain matrix product with 64-bit sums truncated to the result width.
    function automatic logic [C_W-1:0] model(input logic [AB_W-1:0] a, input logic [AB_W-1:0] b);
        logic [C_W-1:0] r;
        longint         s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) begin
                    s += longint'($signed(a[(i*N+k)*DW +: DW])) * longint'($signed(b[(k*N+j)*DW +: DW]));
                end
                r[(i*N+j)*AW +: AW] = s[AW-1:0];
            end
        end
        return r;
    endfunction

    // Issue one multiply from IDLE and watch it finish within a bounded window.
    task automatic run_mult(input logic [AB_W-1:0] a, input logic [AB_W-1:0] b,
                            output logic [C_W-1:0] c, output int done_cyc,
                            output int ready_low, output int done_cnt);
        c         = '0;
        done_cyc  = -1;
        ready_low = 0;
        done_cnt  = 0;
        bus.start = 1'b1;
        bus.a_blk = a;
        bus.b_blk = b;
        tick();
        bus.start = 1'b0;
        bus.a_blk = {$urandom(), $urandom()};
        bus.b_blk = {$urandom(), $urandom()};
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (!bus.ready) ready_low++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    c        = bus.c_blk;
                end
            end
            if (done_cyc >= 0 && cyc > done_cyc) break;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t            tbl [4];
        logic [C_W-1:0]  c;
        logic [C_W-1:0]  c_first;
        logic [C_W-1:0]  c_mid;
        logic [C_W-1:0]  c_second;
        logic [AB_W-1:0] ra;
        logic [AB_W-1:0] rb;
        int              dcyc;
        int              rlow;
        int              dcnt;
        int              d1;
        int              d2;
        int              dn;
        int              rhi;

        tbl[0].name = "identity";
        tbl[0].a = '{16'sd1, 16'sd0, 16'sd0, 16'sd1};
        tbl[0].b = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        tbl[0].c = '{32'sd1, 32'sd2, 32'sd3, 32'sd4};
        tbl[1].name = "signed";
        tbl[1].a = '{-16'sd1, 16'sd2, 16'sd3, -16'sd4};
        tbl[1].b = '{16'sd5, 16'sd6, 16'sd7, 16'sd8};
        tbl[1].c = '{32'sd9, 32'sd10, -32'sd13, -32'sd14};
        tbl[2].name = "wrap";
        tbl[2].a = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
        tbl[2].b = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
        tbl[2].c = '{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000};
        tbl[3].name = "two_ones";
        tbl[3].a = '{16'sd2, 16'sd0, 16'sd0, 16'sd2};
        tbl[3].b = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        tbl[3].c = '{32'sd2, 32'sd2, 32'sd2, 32'sd2};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a_blk = '0;
        bus.b_blk = '0;
        tick();
        tick();
        chk("reset_ready", C_W'(bus.ready), C_W'(1));
        chk("reset_done", C_W'(bus.done), C_W'(0));
        chk("reset_c_blk", bus.c_blk, '0);
        rst = 1'b0;
        tick();

        // Directed table
        for (int v = 0; v < 4; v++) begin
            run_mult(pk_ab(tbl[v].a), pk_ab(tbl[v].b), c, dcyc, rlow, dcnt);
            chk({tbl[v].name, "_c"}, c, pk_c(tbl[v].c));
            chk({tbl[v].name, "_latency"}, C_W'(dcyc), C_W'(LAT));
            chk({tbl[v].name, "_ready_low"}, C_W'(rlow), C_W'(LAT));
            chk({tbl[v].name, "_done_width"}, C_W'(dcnt), C_W'(1));
        end

        // Random operands against the reference product
        for (int r = 0; r < 16; r++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            run_mult(ra, rb, c, dcyc, rlow, dcnt);
            chk($sformatf("rand%0d_c", r), c, model(ra, rb));
            chk($sformatf("rand%0d_latency", r), C_W'(dcyc), C_W'(LAT));
        end

        // Busy/back-to-back: start held high the whole time, operands garbage while busy
        d1 = -1; d2 = -1; dn = 0; rhi = 0;
        c_first = '0; c_mid = '0; c_second = '0;
        bus.start = 1'b1;
        bus.a_blk = pk_ab(tbl[0].a);
        bus.b_blk = pk_ab(tbl[0].b);
        tick();
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (bus.done) begin
                dn++;
                if (d1 < 0) begin
                    d1 = cyc;
                    c_first = bus.c_blk;
                end else begin
                    d2 = cyc;
                    c_second = bus.c_blk;
                end
            end
            if (bus.ready) rhi++;
            if (cyc == 8) c_mid = bus.c_blk;
            if (cyc < 6) begin
                bus.a_blk = {$urandom(), $urandom()};
                bus.b_blk = {$urandom(), $urandom()};
            end else if (cyc == 6) begin
                bus.a_blk = pk_ab(tbl[3].a);
                bus.b_blk = pk_ab(tbl[3].b);
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        chk("b2b_done_count", C_W'(dn), C_W'(2));
        chk("b2b_first_done_cycle", C_W'(d1), C_W'(LAT));
        chk("b2b_second_done_cycle", C_W'(d2), C_W'(2 * LAT + 1));
        chk("b2b_ready_high_cycles", C_W'(rhi), C_W'(2));
        chk("b2b_first_c", c_first, pk_c(tbl[0].c));
        chk("b2b_c_held", c_mid, pk_c(tbl[0].c));
        chk("b2b_second_c", c_second, pk_c(tbl[3].c));

        // Reset during COMPUTE
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        bus.start = 1'b1;
        bus.a_blk = ra;
        bus.b_blk = rb;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", C_W'(bus.ready), C_W'(1));
        chk("abort_done", C_W'(bus.done), C_W'(0));
        chk("abort_c_cleared", bus.c_blk, '0);
        dn = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (bus.done) dn++;
            tick();
        end
        chk("abort_no_done", C_W'(dn), C_W'(0));
        ra = {$urandom(), $urandom()};
        rb = {$urandom(), $urandom()};
        run_mult(ra, rb, c, dcyc, rlow, dcnt);
        chk("after_abort_c", c, model(ra, rb));
        chk("after_abort_latency", C_W'(dcyc), C_W'(LAT));

        // Reset and start on the same edge in IDLE
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a_blk = {$urandom(), $urandom()};
        bus.b_blk = {$urandom(), $urandom()};
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        dn   = 0;
        rlow = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (bus.done) dn++;
            if (!bus.ready) rlow++;
            tick();
        end
        chk("rst_start_no_done", C_W'(dn), C_W'(0));
        chk("rst_start_ready_low", C_W'(rlow), C_W'(0));
        chk("rst_start_c_cleared", bus.c_blk, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
